// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: operand sequencer and result collector for mac_unit.
// A run clears the accumulator and streams VEC_LEN (x, w) pairs from two
// synchronous-read memories. It then waits for the MAC pipeline to drain and
// returns the dot product on a valid/ready port. One result per start.
module mac_seq_ctrl #(
    parameter int VEC_LEN  = 784,
    parameter int X_ADDR_W = 10,
    parameter int W_ADDR_W = 13,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int MAC_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W_ADDR_W-1:0] w_base,
    output logic                busy,
    output logic [X_ADDR_W-1:0] x_addr,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic                rd_en,
    input  logic [DATA_W-1:0]   x_rdata,
    input  logic [DATA_W-1:0]   w_rdata,
    output logic [DATA_W-1:0]   din_x,
    output logic [DATA_W-1:0]   din_w,
    output logic                valid_in,
    output logic                clr_acc,
    input  logic [ACC_W-1:0]    dout,
    output logic [ACC_W-1:0]    res_data,
    output logic                res_valid,
    input  logic                res_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_HOLD
    } state_t;

    // Drain counter runs 0..MAC_LAT, giving 1+MAC_LAT drain cycles.
    localparam int DRAIN_W = $clog2(MAC_LAT + 2);
    localparam logic [X_ADDR_W-1:0] LAST_IDX  = X_ADDR_W'(VEC_LEN - 1);
    localparam logic [DRAIN_W-1:0]  LAST_DRAIN = DRAIN_W'(MAC_LAT);

    state_t              state_reg, state_next;
    logic [X_ADDR_W-1:0] idx_reg, idx_next;
    logic [W_ADDR_W-1:0] w_base_reg, w_base_next;
    logic [DRAIN_W-1:0]  drain_reg, drain_next;
    logic [ACC_W-1:0]    res_data_reg, res_data_next;
    logic                valid_in_reg;

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            idx_reg      <= '0;
            w_base_reg   <= '0;
            drain_reg    <= '0;
            res_data_reg <= '0;
            valid_in_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            w_base_reg   <= w_base_next;
            drain_reg    <= drain_next;
            res_data_reg <= res_data_next;
            // Read data returns one cycle after rd_en, so valid_in follows it by one.
            valid_in_reg <= rd_en;
        end
    end

    // Next-state logic: sequencing, index/drain counting and result capture.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        w_base_next   = w_base_reg;
        drain_next    = drain_reg;
        res_data_next = res_data_reg;
        case (state_reg)
            S_IDLE: begin
                // The base is only latched here, so start while busy cannot disturb it.
                if (start) begin
                    w_base_next = w_base;
                    state_next  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                idx_next   = '0;
                drain_next = '0;
                state_next = S_STREAM;
            end
            S_STREAM: begin
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = S_DRAIN;
                end else begin
                    idx_next = idx_reg + X_ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                // The final edge of DRAIN is the first one at which dout includes the last product.
                if (drain_reg == LAST_DRAIN) begin
                    res_data_next = dout;
                    state_next    = S_HOLD;
                end else begin
                    drain_next = drain_reg + DRAIN_W'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state; addresses read as zero outside STREAM.
    always_comb begin
        busy      = (state_reg != S_IDLE);
        rd_en     = (state_reg == S_STREAM);
        clr_acc   = (state_reg == S_CLEAR);
        res_valid = (state_reg == S_HOLD);
        x_addr    = '0;
        w_addr    = '0;
        if (state_reg == S_STREAM) begin
            x_addr = idx_reg;
            // Truncating or zero-extending idx and then adding wraps modulo 2^W_ADDR_W.
            w_addr = w_base_reg + W_ADDR_W'(idx_reg);
        end
    end

    assign din_x    = x_rdata;
    assign din_w    = w_rdata;
    assign valid_in = valid_in_reg;
    assign res_data = res_data_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed bench for mac_seq_ctrl with behavioural memories and MAC.
// Expected addresses and results are queued when a run is started. Monitors pop
// them when the DUT issues reads or hands over a result.
module tb_mac_seq_ctrl;
    localparam int VL  = 4;
    localparam int XW  = 10;
    localparam int WW  = 13;
    localparam int DW  = 16;
    localparam int AW  = 40;
    localparam int ML  = 1;
    localparam int WW2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, res_ready;
    logic [WW-1:0] w_base;
    logic          busy, rd_en, valid_in, clr_acc, res_valid;
    logic [XW-1:0] x_addr;
    logic [WW-1:0] w_addr;
    logic [DW-1:0] x_rdata, w_rdata, din_x, din_w;
    logic [AW-1:0] dout, res_data;

    // Second instance with a 3-bit weight address, used for the wrap check.
    logic           start2;
    logic [WW2-1:0] w_base2;
    logic           busy2, rd_en2, valid_in2, clr_acc2, res_valid2;
    logic [XW-1:0]  x_addr2;
    logic [WW2-1:0] w_addr2;
    logic [DW-1:0]  din_x2, din_w2;
    logic [AW-1:0]  res_data2;
    logic [DW-1:0]  zero_data = '0;
    logic [AW-1:0]  zero_acc  = '0;
    logic           one_bit   = 1'b1;

    mac_seq_ctrl #(.VEC_LEN(VL), .X_ADDR_W(XW), .W_ADDR_W(WW), .DATA_W(DW),
                   .ACC_W(AW), .MAC_LAT(ML)) dut (
        .clk(clk), .rst(rst), .start(start), .w_base(w_base), .busy(busy),
        .x_addr(x_addr), .w_addr(w_addr), .rd_en(rd_en), .x_rdata(x_rdata),
        .w_rdata(w_rdata), .din_x(din_x), .din_w(din_w), .valid_in(valid_in),
        .clr_acc(clr_acc), .dout(dout), .res_data(res_data),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    mac_seq_ctrl #(.VEC_LEN(VL), .X_ADDR_W(XW), .W_ADDR_W(WW2), .DATA_W(DW),
                   .ACC_W(AW), .MAC_LAT(ML)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .w_base(w_base2), .busy(busy2),
        .x_addr(x_addr2), .w_addr(w_addr2), .rd_en(rd_en2), .x_rdata(zero_data),
        .w_rdata(zero_data), .din_x(din_x2), .din_w(din_w2), .valid_in(valid_in2),
        .clr_acc(clr_acc2), .dout(zero_acc), .res_data(res_data2),
        .res_valid(res_valid2), .res_ready(one_bit)
    );

    // Synchronous-read operand memories.
    logic [DW-1:0] x_mem [0:(1<<XW)-1];
    logic [DW-1:0] w_mem [0:(1<<WW)-1];
    always @(posedge clk) begin
        if (rd_en) begin
            x_rdata <= x_mem[x_addr];
            w_rdata <= w_mem[w_addr];
        end
    end

    // Behavioural mac_unit: Q8.8 x Q8.8 product rescaled to Q8.8, accumulated, 1-cycle latency.
    logic signed [AW-1:0]     acc;
    logic signed [2*DW-1:0]   prod, prod_sh;
    assign prod    = $signed(din_x) * $signed(din_w);
    assign prod_sh = prod >>> 8;
    assign dout    = acc;
    always @(posedge clk) begin
        if (rst || clr_acc) acc <= '0;
        else if (valid_in) acc <= acc + {{(AW-2*DW){prod_sh[2*DW-1]}}, prod_sh};
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference dot product over the bench memories.
    function automatic logic [AW-1:0] exp_dot(input int base);
        logic signed [AW-1:0]   s;
        logic signed [2*DW-1:0] p;
        s = '0;
        for (int i = 0; i < VL; i++) begin
            p = $signed(x_mem[i]) * $signed(w_mem[(base + i) % (1 << WW)]);
            p = p >>> 8;
            s = s + {{(AW-2*DW){p[2*DW-1]}}, p};
        end
        return s;
    endfunction

    logic [XW-1:0]  exp_x_q [$];
    logic [WW-1:0]  exp_w_q [$];
    logic [AW-1:0]  exp_res_q [$];
    logic [XW-1:0]  exp2_x_q [$];
    logic [WW2-1:0] exp2_w_q [$];

    int results_seen = 0;
    int vi_run = 0;
    int last_run = 0;

    // Monitor for the main instance: addresses, valid_in runs and result handshakes.
    always @(negedge clk) begin : mon
        logic [AW-1:0] e;
        if (rd_en) begin
            if (exp_x_q.size() == 0) check("rd_en_unexpected", rd_en, 0);
            else begin
                check("x_addr", x_addr, exp_x_q.pop_front());
                check("w_addr", w_addr, exp_w_q.pop_front());
            end
        end
        if (rst) vi_run = 0;
        else if (valid_in) begin
            vi_run++;
            check("valid_in_with_clr", clr_acc, 0);
        end else if (vi_run != 0) begin
            last_run = vi_run;
            vi_run = 0;
        end
        if (res_valid && res_ready) begin
            if (exp_res_q.size() == 0) check("res_unexpected", res_valid, 0);
            else begin
                e = exp_res_q.pop_front();
                $display("result transfer: res_data=%h expected=%h", res_data, e);
                check("res_data", res_data, e);
            end
            results_seen++;
        end
    end

    // Monitor for the wrap instance: addresses only.
    always @(negedge clk) begin
        if (rd_en2) begin
            if (exp2_x_q.size() == 0) check("rd_en2_unexpected", rd_en2, 0);
            else begin
                check("wrap_x_addr", x_addr2, exp2_x_q.pop_front());
                check("wrap_w_addr", w_addr2, exp2_w_q.pop_front());
            end
        end
    end

    task automatic push_run(input int base);
        for (int i = 0; i < VL; i++) begin
            exp_x_q.push_back(XW'(i));
            exp_w_q.push_back(WW'((base + i) % (1 << WW)));
        end
        exp_res_q.push_back(exp_dot(base));
    endtask

    // Raise start for one edge; returns 1 time unit after the accepting edge.
    task automatic go(input int base, input bit expect_run);
        @(posedge clk); #1;
        start  = 1'b1;
        w_base = WW'(base);
        if (expect_run) push_run(base);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles after the start edge until res_valid is seen; bounded.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (res_valid) break;
            cyc++;
        end
        if (cyc >= 100) check("res_valid_timeout", res_valid, 1);
    endtask

    initial begin : main
        int c;
        int seen0;
        for (int i = 0; i < (1 << XW); i++) x_mem[i] = '0;
        for (int i = 0; i < (1 << WW); i++) w_mem[i] = '0;
        x_mem[0] = 16'h0080; x_mem[1] = 16'h0100; x_mem[2] = 16'h0080; x_mem[3] = 16'hFE00;
        w_mem[0] = 16'h0200; w_mem[1] = 16'h0100; w_mem[2] = 16'hFF00; w_mem[3] = 16'hFF80;
        for (int i = 8; i < 12; i++) w_mem[i] = 16'h0100;

        rst = 1'b1; start = 1'b0; w_base = '0; res_ready = 1'b1;
        start2 = 1'b0; w_base2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_valid_in", valid_in, 0);
        check("rst_clr_acc", clr_acc, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_x_addr", x_addr, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_res_data", res_data, 0);

        // Basic dot product with latency and valid_in run length.
        go(0, 1);
        check("clear_cycle_clr_acc", clr_acc, 1);
        wait_result(c);
        check("latency_basic", c, VL + 2 + ML);
        check("basic_res_const", res_data, 40'h0000000280);
        @(negedge clk);
        check("basic_busy_after", busy, 0);
        check("valid_in_run", last_run, VL);

        // Back-pressure: result must hold while res_ready is low.
        res_ready = 1'b0;
        go(0, 1);
        wait_result(c);
        check("latency_bp", c, VL + 2 + ML);
        for (int k = 0; k < 6; k++) begin
            check("bp_res_valid", res_valid, 1);
            check("bp_res_data", res_data, 40'h0000000280);
            @(negedge clk);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_busy_after", busy, 0);
        check("bp_res_valid_after", res_valid, 0);
        check("bp_results_seen", results_seen, 2);

        // Back-to-back: second start in the IDLE cycle right after the handshake.
        go(0, 1);
        wait_result(c);
        go(8, 1);
        wait_result(c);
        check("latency_b2b", c, VL + 2 + ML);
        check("b2b_res_cleared", res_data, 40'h0000000000);
        @(negedge clk);
        check("b2b_busy_after", busy, 0);

        // start pulsed mid-STREAM with another base is ignored.
        seen0 = results_seen;
        go(0, 1);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; w_base = WW'(5);
        @(posedge clk); #1 start = 1'b0; w_base = '0;
        wait_result(c);
        repeat (20) @(negedge clk);
        check("busy_start_one_result", results_seen - seen0, 1);
        check("busy_start_idle", busy, 0);

        // Reset during the third STREAM cycle abandons the run.
        go(0, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_x_q.delete(); exp_w_q.delete(); exp_res_q.delete();
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_valid_in", valid_in, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_x_addr", x_addr, 0);
        go(0, 1);
        wait_result(c);
        check("after_rst_res", res_data, 40'h0000000280);
        @(negedge clk);
        check("after_rst_vi_run", last_run, VL);

        // Weight address wrap on the 3-bit instance: 6,7,0,1.
        @(posedge clk); #1;
        start2 = 1'b1; w_base2 = 3'd6;
        for (int i = 0; i < VL; i++) begin
            exp2_x_q.push_back(XW'(i));
            exp2_w_q.push_back(WW2'((6 + i) % 8));
        end
        @(posedge clk); #1 start2 = 1'b0;
        c = 0;
        while (busy2 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("wrap_done", busy2, 0);
        check("wrap_queue_left", exp2_x_q.size(), 0);

        check("final_addr_queue_left", exp_x_q.size(), 0);
        check("final_res_queue_left", exp_res_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
